// File: rtl/multi_nibble_alu_if.sv
// multi_nibble_alu_if: request/response bundle for the multi-nibble ALU.
// master drives the request side, slave (the ALU) drives status and results.
interface multi_nibble_alu_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [2:0]            op;
  logic                  decimal;
  logic                  carry_in;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   result;
  logic                  carry_out;
  logic                  zero_out;

  modport master (
    output start, op, decimal, carry_in, a, b,
    input  busy, done, result, carry_out, zero_out
  );

  modport slave (
    input  start, op, decimal, carry_in, a, b,
    output busy, done, result, carry_out, zero_out
  );
endinterface

// File: rtl/multi_nibble_alu.sv
// multi_nibble_alu: serial LSB-first add/subtract over DIGITS nibbles.
// Define MULTI_NIBBLE_ALU_DECIMAL_EN to build the per-nibble BCD adjust.
module multi_nibble_alu #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  multi_nibble_alu_if.slave   alu_bus
);

  localparam int W = 4 * DIGITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SBC = 3'b011;

  localparam logic [2:0] LAST = 3'(DIGITS - 1);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [2:0]   op_q, op_d;
  logic         dec_q, dec_d;
  logic         c_q, c_d;
  logic [2:0]   idx_q, idx_d;
  logic         zacc_q, zacc_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic [W-1:0] result_q, result_d;
  logic         carry_q, carry_d;
  logic         zero_q, zero_d;

  logic         accept;
  logic         is_add;
  logic         wr_res;
  logic [4:0]   s_add, s_sub;
  logic [4:0]   s_add6, s_sub6;
  logic [3:0]   nib;
  logic         cy;
  logic [W+3:0] a_ext, b_ext, sh_ext;

  assign alu_bus.busy      = (state_q == S_RUN);
  assign alu_bus.done      = (state_q == S_DONE);
  assign alu_bus.result    = result_q;
  assign alu_bus.carry_out = carry_q;
  assign alu_bus.zero_out  = zero_q;

  assign accept = alu_bus.start &&
                  (state_q == S_IDLE || state_q == S_DONE);
  assign is_add = (op_q == OP_ADD) || (op_q == OP_ADC);
  assign wr_res = ~op_q[2];

  assign s_add  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'd0, c_q};
  assign s_sub  = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'd0, c_q};
  assign s_add6 = s_add + 5'd6;
  assign s_sub6 = s_sub - 5'd6;

`ifdef MULTI_NIBBLE_ALU_DECIMAL_EN
  assign dec_d = accept ? alu_bus.decimal : dec_q;
`else
  logic unused_decimal;
  assign unused_decimal = alu_bus.decimal ^ dec_q;
  assign dec_d = 1'b0;
`endif

  // One nibble of ripple arithmetic with optional decimal adjust
  always_comb begin
    nib = is_add ? s_add[3:0] : s_sub[3:0];
    cy  = is_add ? s_add[4]   : s_sub[4];
`ifdef MULTI_NIBBLE_ALU_DECIMAL_EN
    if (dec_q) begin
      if (is_add && (s_add > 5'd9)) begin
        nib = s_add6[3:0];
        cy  = 1'b1;
      end else if (!is_add && s_sub[4]) begin
        nib = s_sub6[3:0];
        cy  = 1'b1;
      end
    end
`else
    if (dec_q) begin
      nib = 4'h0;
      cy  = 1'b0;
    end
`endif
  end

  assign a_ext  = {4'h0, a_q};
  assign b_ext  = {4'h0, b_q};
  assign sh_ext = {nib, shadow_q};

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    c_d      = c_q;
    idx_d    = idx_q;
    zacc_d   = zacc_q;
    shadow_d = shadow_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    case (state_q)
      S_RUN: begin
        a_d      = a_ext[W+3:4];
        b_d      = b_ext[W+3:4];
        c_d      = cy;
        zacc_d   = zacc_q & (nib == 4'h0);
        shadow_d = sh_ext[W+3:4];
        if (idx_q == LAST) begin
          state_d = S_DONE;
          carry_d = cy;
          zero_d  = zacc_q & (nib == 4'h0);
          if (wr_res)
            result_d = sh_ext[W+3:4];
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      state_d = S_RUN;
      a_d     = alu_bus.a;
      b_d     = alu_bus.b;
      op_d    = alu_bus.op;
      c_d     = alu_bus.carry_in &&
                (alu_bus.op == OP_ADC || alu_bus.op == OP_SBC);
      idx_d   = 3'd0;
      zacc_d  = 1'b1;
    end
  end

  // State and output registers; reset drops any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 3'd0;
      dec_q    <= 1'b0;
      c_q      <= 1'b0;
      idx_q    <= 3'd0;
      zacc_q   <= 1'b1;
      shadow_q <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      dec_q    <= dec_d;
      c_q      <= c_d;
      idx_q    <= idx_d;
      zacc_q   <= zacc_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_multi_nibble_alu.sv
// tb_multi_nibble_alu: directed vectors for 4-digit and 1-digit builds.
// Expected values follow the decimal build when the macro is defined.
module tb_multi_nibble_alu;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   cyc;

  multi_nibble_alu_if #(.DIGITS(4)) m4 ();
  multi_nibble_alu_if #(.DIGITS(1)) m1 ();

  multi_nibble_alu #(.DIGITS(4)) dut4 (
    .clk     (clk),
    .reset   (rst),
    .alu_bus (m4.slave)
  );

  multi_nibble_alu #(.DIGITS(1)) dut1 (
    .clk     (clk),
    .reset   (rst),
    .alu_bus (m1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at #1 after an edge with the DUT idle or in DONE.
  task automatic run_op(input logic [2:0] op,
                        input logic dec,
                        input logic cin,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        output int cyc_o);
    m4.op       = op;
    m4.decimal  = dec;
    m4.carry_in = cin;
    m4.a        = a;
    m4.b        = b;
    m4.start    = 1'b1;
    @(posedge clk);
    #1;
    m4.start    = 1'b0;
    m4.a        = ~a;
    m4.b        = ~b;
    m4.op       = ~op;
    m4.carry_in = ~cin;
    m4.decimal  = ~dec;
    cyc_o = 0;
    while (!m4.done && cyc_o < 20) begin
      @(posedge clk);
      #1;
      cyc_o++;
    end
  endtask

  initial begin
    logic [15:0] e_adc, e_sbc;
    logic [3:0]  e_d1;
    n_tests = 0;
    n_fail  = 0;
`ifdef MULTI_NIBBLE_ALU_DECIMAL_EN
    e_adc = 16'h1000;
    e_sbc = 16'h9999;
    e_d1  = 4'h7;
`else
    e_adc = 16'h099A;
    e_sbc = 16'hFFFF;
    e_d1  = 4'hD;
`endif
    m4.start = 0; m4.op = 0; m4.decimal = 0;
    m4.carry_in = 0; m4.a = 0; m4.b = 0;
    m1.start = 0; m1.op = 0; m1.decimal = 0;
    m1.carry_in = 0; m1.a = 0; m1.b = 0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_busy", 32'(m4.busy), 32'd0);
    chk("rst_done", 32'(m4.done), 32'd0);
    chk("rst_result", 32'(m4.result), 32'd0);
    chk("rst_carry", 32'(m4.carry_out), 32'd0);
    chk("rst_zero", 32'(m4.zero_out), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ADD ignores carry_in
    m4.op = 3'b000; m4.decimal = 0; m4.carry_in = 1;
    m4.a = 16'h1234; m4.b = 16'h0FFF; m4.start = 1;
    @(posedge clk);
    #1;
    m4.start = 0;
    m4.a = 16'hFFFF;
    chk("add_busy", 32'(m4.busy), 32'd1);
    cyc = 0;
    while (!m4.done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("add_lat", 32'(cyc), 32'd4);
    chk("add_busy_low", 32'(m4.busy), 32'd0);
    chk("add_res", 32'(m4.result), 32'h2233);
    chk("add_c", 32'(m4.carry_out), 32'd0);
    chk("add_z", 32'(m4.zero_out), 32'd0);
    @(posedge clk);
    #1;
    chk("add_done_pulse", 32'(m4.done), 32'd0);

    run_op(3'b001, 1'b1, 1'b0, 16'h0999, 16'h0001, cyc);
    chk("adc_lat", 32'(cyc), 32'd4);
    chk("adc_res", 32'(m4.result), 32'(e_adc));
    chk("adc_c", 32'(m4.carry_out), 32'd0);
    chk("adc_z", 32'(m4.zero_out), 32'd0);
    @(posedge clk);
    #1;

    run_op(3'b011, 1'b1, 1'b0, 16'h0000, 16'h0001, cyc);
    chk("sbc_res", 32'(m4.result), 32'(e_sbc));
    chk("sbc_c", 32'(m4.carry_out), 32'd1);
    chk("sbc_z", 32'(m4.zero_out), 32'd0);
    @(posedge clk);
    #1;

    run_op(3'b010, 1'b0, 1'b0, 16'h5A5A, 16'h5A5A, cyc);
    chk("sub_res", 32'(m4.result), 32'h0000);
    chk("sub_z", 32'(m4.zero_out), 32'd1);
    chk("sub_c", 32'(m4.carry_out), 32'd0);
    // back-to-back CP issued from DONE
    run_op(3'b100, 1'b0, 1'b0, 16'h0003, 16'h0004, cyc);
    chk("cp_lat", 32'(cyc), 32'd4);
    chk("cp_res_hold", 32'(m4.result), 32'h0000);
    chk("cp_c", 32'(m4.carry_out), 32'd1);
    chk("cp_z", 32'(m4.zero_out), 32'd0);
    @(posedge clk);
    #1;

    // start pulse during RUN is ignored
    m4.op = 3'b000; m4.decimal = 0; m4.carry_in = 0;
    m4.a = 16'h1111; m4.b = 16'h2222; m4.start = 1;
    @(posedge clk);
    #1;
    m4.start = 0;
    @(posedge clk);
    #1;
    m4.a = 16'h4444; m4.b = 16'h4444; m4.start = 1;
    @(posedge clk);
    #1;
    m4.start = 0;
    cyc = 2;
    while (!m4.done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("ign_lat", 32'(cyc), 32'd4);
    chk("ign_res", 32'(m4.result), 32'h3333);
    @(posedge clk);
    #1;
    chk("ign_no_rerun", 32'(m4.busy), 32'd0);

    // reset two cycles after accept
    m4.a = 16'h0F0F; m4.b = 16'h0101; m4.start = 1;
    @(posedge clk);
    #1;
    m4.start = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(m4.busy), 32'd0);
    chk("mid_rst_done", 32'(m4.done), 32'd0);
    chk("mid_rst_res", 32'(m4.result), 32'd0);
    chk("mid_rst_c", 32'(m4.carry_out), 32'd0);
    chk("mid_rst_z", 32'(m4.zero_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op(3'b000, 1'b0, 1'b0, 16'h0001, 16'h0001, cyc);
    chk("post_rst_res", 32'(m4.result), 32'h0002);
    chk("post_rst_lat", 32'(cyc), 32'd4);

    // single-digit SBC with borrow in
    m1.op = 3'b011; m1.decimal = 1; m1.carry_in = 1;
    m1.a = 4'h7; m1.b = 4'h9; m1.start = 1;
    @(posedge clk);
    #1;
    m1.start = 0;
    m1.a = 4'h0;
    cyc = 0;
    while (!m1.done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("d1_lat", 32'(cyc), 32'd1);
    chk("d1_res", 32'(m1.result), 32'(e_d1));
    chk("d1_c", 32'(m1.carry_out), 32'd1);
    chk("d1_z", 32'(m1.zero_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
